mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit. A Moore FSM sequences the shared datapath (one memory, one ALU, PC/IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It instantiates the existing ALU decoder, driving it with a 2-bit aluop. It also keeps a retired-instruction counter. It sits between the instruction register fields and the multicycle datapath's mux selects and write enables.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0], passed to ALU decoder
- zero  in  1  ALU zero flag, combinational from datapath
- iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca  out  1 each  datapath controls
- alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- pcen  out  1  PC register enable
- alucontrol  out  3  from ALU decoder
- illegal  out  1  one-cycle pulse on an unsupported opcode
- instret  out  CNT_W  count of completed instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Outputs are decoded from the state only. Exception: pcen. Unlisted outputs are 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - anything else → FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1, then MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10, then ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00, then ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP are terminal states; each returns to FETCH.
- pcen = pcwrite | (branch & zero), combinational.
- instret increments by 1 on each terminal→FETCH transition. It wraps modulo 2^CNT_W. An illegal-op return does not increment it.

## Timing
- Reset asserted: state=FETCH immediately (async), instret=0, illegal=0.
- While reset is asserted, irwrite, pcen, regwrite and memwrite are forced to 0. Other outputs show FETCH values.
- Reset mid-instruction aborts it; the instruction is not counted.
- First FETCH is the first rising edge after reset deasserts.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- alucontrol follows aluop/funct combinationally with no added latency.
- zero is sampled only in BRANCH; in every other state pcen ignores it.

## Configuration
- MC_BNE_EN defined:
  - op 000101 (bne) in DECODE → BRANCH.
  - A registered isbne flag is captured in DECODE.
  - pcen = pcwrite | (branch & (zero ^ isbne)).
  - bne takes 3 cycles and counts in instret.
- MC_BNE_EN undefined: 000101 is illegal and the isbne logic is absent.

## Structure
- Package mc_pkg holds the state_t enum (logic [3:0]), the opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J) and the aluop localparams.
- Natural sub-module: mc_fsm_out, a pure combinational state→control-vector decode.
- mc_controller holds the state register, next-state logic, pcen, instret, and the aludec instance.

## Test plan
- Reset pulse mid-EXECUTE → state FETCH at once, instret=0, irwrite=0 until reset deasserts.
- lw (op=100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5; instret +1.
- R-type add (op=000000, funct=100000) → in EXECUTE, alucontrol=010 and alusrcb=00; in ALUWB, regdst=1; 4 cycles.
- beq with zero=1 → pcen=1 and pcsrc=01 in BRANCH. Repeat with zero=0 → pcen=0; both take 3 cycles.
- op=111111 → illegal=1 in the DECODE cycle, FETCH next, instret unchanged.
- With instret preloaded to 0xFFFFFFFF via a force, one j → instret=0. With MC_BNE_EN defined, bne with zero=0 → pcen=1.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: states, opcodes, aluop encodings and control vector for the multicycle controller
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;
endpackage

// File: rtl/aludec.sv
// aludec: maps aluop and R-type funct to the 3-bit ALU control
module aludec (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    logic [2:0] fdec;
    always_comb begin
        case (funct)
            6'b100000: fdec = 3'b010;
            6'b100010: fdec = 3'b110;
            6'b100100: fdec = 3'b000;
            6'b100101: fdec = 3'b001;
            6'b101010: fdec = 3'b111;
            default:   fdec = 3'b010;
        endcase
    end
    assign alucontrol = aluop == 2'b00 ? 3'b010 : aluop == 2'b01 ? 3'b110 : fdec;
endmodule

// File: rtl/mc_fsm_out.sv
// mc_fsm_out: pure state-to-control-vector decode for the multicycle controller
module mc_fsm_out
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            DECODE:   ctrl.alusrcb = 2'b11;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            MEMRD:    ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            ADDIWB:   ctrl.regwrite = 1'b1;
            JUMP: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default:  ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with retired-instruction counter; MC_BNE_EN adds bne
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    state_t state, next;
    ctrl_t  ctrl;
    logic   terminal;
    logic   taken;

    mc_fsm_out u_out (.state(state), .ctrl(ctrl));
    aludec u_aludec (.aluop(ctrl.aluop), .funct(funct), .alucontrol(alucontrol));

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else       state <= next;

    always_comb begin
        next    = FETCH;
        illegal = 1'b0;
        case (state)
            FETCH: next = DECODE;
            DECODE:
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = EXECUTE;
                    OP_BEQ:       next = BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       next = BRANCH;
`endif
                    OP_ADDI:      next = ADDIEXEC;
                    OP_J:         next = JUMP;
                    default:      illegal = 1'b1;
                endcase
            MEMADR:   next = op == OP_SW ? MEMWR : MEMRD;
            MEMRD:    next = MEMWB;
            EXECUTE:  next = ALUWB;
            ADDIEXEC: next = ADDIWB;
            default:  next = FETCH;
        endcase
    end

`ifdef MC_BNE_EN
    logic isbne;
    always_ff @(posedge clk or posedge reset)
        if (reset)                isbne <= 1'b0;
        else if (state == DECODE) isbne <= op == OP_BNE;
    assign taken = ctrl.branch & (zero ^ isbne);
`else
    assign taken = ctrl.branch & zero;
`endif

    assign terminal = state inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP};

    always_ff @(posedge clk or posedge reset)
        if (reset)         instret <= '0;
        else if (terminal) instret <= instret + CNT_W'(1);

    assign iord     = ctrl.iord;
    assign irwrite  = ctrl.irwrite & ~reset;
    assign memwrite = ctrl.memwrite & ~reset;
    assign regwrite = ctrl.regwrite & ~reset;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign pcen     = (ctrl.pcwrite | taken) & ~reset;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven directed checks of the multicycle controller
module tb_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] instret;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          cycles;
        int          key;
        logic [15:0] outs;
        int          delta;
    } vec_t;

    vec_t tbl[16];
    int   nvec;

    // iord irwrite memwrite regwrite regdst memtoreg alusrca alusrcb pcsrc pcen alucontrol illegal
    function automatic logic [15:0] outs_now();
        return {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int cyc, input int key, input logic [15:0] outs, input int delta);
        tbl[nvec] = '{name, o, f, z, cyc, key, outs, delta};
        nvec++;
    endtask

    task automatic run(input vec_t v);
        op = v.op;
        funct = v.funct;
        zero = v.zero;
        for (int c = 1; c <= v.cycles; c++) begin
            @(negedge clk);
            chk({v.name, " irwrite"}, 32'(irwrite), 32'(c == 1));
            if (c == v.key) chk({v.name, " outs"}, 32'(outs_now()), 32'(v.outs));
            @(posedge clk);
            #1;
        end
        exp_cnt = exp_cnt + 32'(v.delta);
        chk({v.name, " back to fetch"}, 32'(irwrite), 32'd1);
        chk({v.name, " instret"}, instret, exp_cnt);
    endtask

    initial begin
        nvec = 0;
        add("lw decode",   6'b100011, 6'd0, 1'b0, 5, 2, 16'b0_0_0_0_0_0_0_11_00_0_010_0, 1);
        add("lw memadr",   6'b100011, 6'd0, 1'b0, 5, 3, 16'b0_0_0_0_0_0_1_10_00_0_010_0, 1);
        add("lw memrd",    6'b100011, 6'd0, 1'b0, 5, 4, 16'b1_0_0_0_0_0_0_00_00_0_010_0, 1);
        add("lw memwb",    6'b100011, 6'd0, 1'b0, 5, 5, 16'b0_0_0_1_0_1_0_00_00_0_010_0, 1);
        add("sw memwr",    6'b101011, 6'd0, 1'b0, 4, 4, 16'b1_0_1_0_0_0_0_00_00_0_010_0, 1);
        add("add exec",    6'b000000, 6'b100000, 1'b1, 4, 3, 16'b0_0_0_0_0_0_1_00_00_0_010_0, 1);
        add("add aluwb",   6'b000000, 6'b100000, 1'b0, 4, 4, 16'b0_0_0_1_1_0_0_00_00_0_010_0, 1);
        add("sub exec",    6'b000000, 6'b100010, 1'b0, 4, 3, 16'b0_0_0_0_0_0_1_00_00_0_110_0, 1);
        add("slt exec",    6'b000000, 6'b101010, 1'b0, 4, 3, 16'b0_0_0_0_0_0_1_00_00_0_111_0, 1);
        add("beq taken",   6'b000100, 6'd0, 1'b1, 3, 3, 16'b0_0_0_0_0_0_1_00_01_1_110_0, 1);
        add("beq nottkn",  6'b000100, 6'd0, 1'b0, 3, 3, 16'b0_0_0_0_0_0_1_00_01_0_110_0, 1);
        add("addi exec",   6'b001000, 6'd0, 1'b0, 4, 3, 16'b0_0_0_0_0_0_1_10_00_0_010_0, 1);
        add("addi wb",     6'b001000, 6'd0, 1'b0, 4, 4, 16'b0_0_0_1_0_0_0_00_00_0_010_0, 1);
        add("j jump",      6'b000010, 6'd0, 1'b0, 3, 3, 16'b0_0_0_0_0_0_0_00_10_1_010_0, 1);
        add("illegal",     6'b111111, 6'd0, 1'b1, 2, 2, 16'b0_0_0_0_0_0_0_11_00_0_010_1, 0);
`ifdef MC_BNE_EN
        add("bne taken",   6'b000101, 6'd0, 1'b0, 3, 3, 16'b0_0_0_0_0_0_1_00_01_1_110_0, 1);
`else
        add("bne illegal", 6'b000101, 6'd0, 1'b0, 2, 2, 16'b0_0_0_0_0_0_0_11_00_0_010_1, 0);
`endif

        #2;
        chk("reset instret", instret, 32'd0);
        chk("reset irwrite", 32'(irwrite), 32'd0);
        chk("reset pcen", 32'(pcen), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset alusrcb", 32'(alusrcb), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < nvec; i++) run(tbl[i]);

        // reset pulse in the middle of an R-type instruction
        op = 6'b000000;
        funct = 6'b100000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid exec alusrca", 32'(alusrca), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid reset instret", instret, 32'd0);
        chk("mid reset irwrite", 32'(irwrite), 32'd0);
        chk("mid reset pcen", 32'(pcen), 32'd0);
        chk("mid reset alusrcb", 32'(alusrcb), 32'd1);
        chk("mid reset alusrca", 32'(alusrca), 32'd0);
        @(posedge clk); #1;
        chk("held reset irwrite", 32'(irwrite), 32'd0);
        chk("held reset regwrite", 32'(regwrite), 32'd0);
        reset = 1'b0;
        #1;
        chk("post reset irwrite", 32'(irwrite), 32'd1);
        chk("post reset pcen", 32'(pcen), 32'd1);
        @(posedge clk); #1;
        chk("post reset decode", 32'(alusrcb), 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_cnt = 32'd1;
        chk("post reset instret", instret, exp_cnt);
        chk("post reset fetch", 32'(irwrite), 32'd1);

        // counter wrap from all-ones
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        chk("preload instret", instret, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        run(tbl[13]);
        chk("wrap instret zero", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
